// File: rtl/cursor_motion_ctrl_if.sv
// Cursor controller bundle: button/tick inputs, cursor position outputs, click event handshake.
// master = producer of buttons and consumer of clicks; slave = cursor_motion_ctrl.
interface cursor_motion_ctrl_if;
    logic        step_tick;
    logic        cursor_en;
    logic        btnL;
    logic        btnR;
    logic        btnU;
    logic        btnD;
    logic        btnC;
    logic [11:0] cursor_x;
    logic [11:0] cursor_y;
    logic [5:0]  speed;
    logic        moving;
    logic        click_valid;
    logic        click_ready;
    logic [11:0] click_x;
    logic [11:0] click_y;
    logic        click_overrun;

    modport master (
        output step_tick, cursor_en, btnL, btnR, btnU, btnD, btnC, click_ready,
        input  cursor_x, cursor_y, speed, moving, click_valid, click_x, click_y, click_overrun
    );

    modport slave (
        input  step_tick, cursor_en, btnL, btnR, btnU, btnD, btnC, click_ready,
        output cursor_x, cursor_y, speed, moving, click_valid, click_x, click_y, click_overrun
    );
endinterface

// File: rtl/cursor_motion_ctrl.sv
// Purpose: buttons -> clamped cursor position with typematic hold and speed ramp, plus click events.
// Latency: all outputs registered, one clk after the qualifying cycle. Optional macro CURSOR_DIAG_EN.
// Backpressure: one pending click held until click_ready; a new press while blocked pulses click_overrun.
module cursor_motion_ctrl #(
    parameter int H_MAX      = 1279,
    parameter int V_MAX      = 1023,
    parameter int X_INIT     = 640,
    parameter int Y_INIT     = 512,
    parameter int HOLD_TICKS = 8,
    parameter int RAMP_TICKS = 4,
    parameter int MAX_SPEED  = 63
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cursor_motion_ctrl_if.slave  cif
);

    localparam logic [12:0] X_MAX13   = 13'(H_MAX);
    localparam logic [12:0] Y_MAX13   = 13'(V_MAX);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);
    localparam logic [15:0] RAMP_LAST = 16'(RAMP_TICKS - 1);
    localparam logic [5:0]  SPD_MAX   = 6'(MAX_SPEED);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t      state_q, state_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic [5:0]  speed_q, speed_d;
    logic [15:0] hold_q, hold_d, ramp_q, ramp_d;
    logic [3:0]  dir_q, dir_d;
    logic        moving_q, moving_d;
    logic        btnc_q, btnc_d;
    logic        cv_q, cv_d;
    logic [11:0] cx_q, cx_d, cy_q, cy_d;
    logic        ovr_q, ovr_d;

    logic [3:0]  btn_dir;
    logic        any_dir, shape_ok, dir_ok, click_edge;
    logic [12:0] step;
    logic [11:0] mv_x, mv_y;

    function automatic logic [11:0] sat_dec(input logic [11:0] pos, input logic [12:0] st);
        logic [12:0] p;
        p = {1'b0, pos};
        return (p < st) ? 12'd0 : 12'(p - st);
    endfunction

    function automatic logic [11:0] sat_inc(input logic [11:0] pos, input logic [12:0] st,
                                            input logic [12:0] lim);
        logic [12:0] s;
        s = {1'b0, pos} + st;
        return (s > lim) ? lim[11:0] : s[11:0];
    endfunction

    always_comb begin
        btn_dir = {cif.btnL, cif.btnR, cif.btnU, cif.btnD};
        any_dir = |btn_dir;
`ifdef CURSOR_DIAG_EN
        // Any non-opposing set: one axis or one horizontal plus one vertical.
        shape_ok = any_dir && !(cif.btnL && cif.btnR) && !(cif.btnU && cif.btnD);
`else
        shape_ok = $onehot(btn_dir);
`endif
        dir_ok     = cif.cursor_en && !cif.btnC && shape_ok;
        click_edge = cif.btnC && !btnc_q && cif.cursor_en && !any_dir;
        step       = (state_q == REPEAT) ? (13'd1 + {7'd0, speed_q}) : 13'd1;

        mv_x = x_q;
        if (btn_dir[3])      mv_x = sat_dec(x_q, step);
        else if (btn_dir[2]) mv_x = sat_inc(x_q, step, X_MAX13);
        mv_y = y_q;
        if (btn_dir[1])      mv_y = sat_dec(y_q, step);
        else if (btn_dir[0]) mv_y = sat_inc(y_q, step, Y_MAX13);
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        speed_d = speed_q;
        hold_d  = hold_q;
        ramp_d  = ramp_q;
        dir_d   = dir_q;

        if (!cif.cursor_en) begin
            state_d = IDLE;
            speed_d = 6'd0;
            hold_d  = 16'd0;
            ramp_d  = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cif.step_tick && dir_ok) begin
                        x_d     = mv_x;
                        y_d     = mv_y;
                        dir_d   = btn_dir;
                        hold_d  = 16'd0;
                        state_d = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    // A release or direction change cancels before any tick is honoured.
                    if (!dir_ok || (btn_dir != dir_q)) begin
                        state_d = IDLE;
                        speed_d = 6'd0;
                        hold_d  = 16'd0;
                        ramp_d  = 16'd0;
                    end else if (cif.step_tick) begin
                        if (state_q == HOLD) begin
                            if (hold_q == HOLD_LAST) begin
                                state_d = REPEAT;
                                speed_d = 6'd0;
                                ramp_d  = 16'd0;
                            end else begin
                                hold_d = hold_q + 16'd1;
                            end
                        end else begin
                            x_d = mv_x;
                            y_d = mv_y;
                            if (ramp_q == RAMP_LAST) begin
                                ramp_d  = 16'd0;
                                speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 6'd1;
                            end else begin
                                ramp_d = ramp_q + 16'd1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        moving_d = (state_d != IDLE);
    end

    always_comb begin
        btnc_d = cif.btnC;
        cv_d   = cv_q;
        cx_d   = cx_q;
        cy_d   = cy_q;
        ovr_d  = 1'b0;
        if (click_edge) begin
            if (!cv_q || cif.click_ready) begin
                cv_d = 1'b1;
                cx_d = x_q;
                cy_d = y_q;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (cv_q && cif.click_ready) begin
            cv_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            x_q      <= 12'(X_INIT);
            y_q      <= 12'(Y_INIT);
            speed_q  <= 6'd0;
            hold_q   <= 16'd0;
            ramp_q   <= 16'd0;
            dir_q    <= 4'd0;
            moving_q <= 1'b0;
            btnc_q   <= 1'b0;
            cv_q     <= 1'b0;
            cx_q     <= 12'd0;
            cy_q     <= 12'd0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            speed_q  <= speed_d;
            hold_q   <= hold_d;
            ramp_q   <= ramp_d;
            dir_q    <= dir_d;
            moving_q <= moving_d;
            btnc_q   <= btnc_d;
            cv_q     <= cv_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            ovr_q    <= ovr_d;
        end
    end

    assign cif.cursor_x      = x_q;
    assign cif.cursor_y      = y_q;
    assign cif.speed         = speed_q;
    assign cif.moving        = moving_q;
    assign cif.click_valid   = cv_q;
    assign cif.click_x       = cx_q;
    assign cif.click_y       = cy_q;
    assign cif.click_overrun = ovr_q;

endmodule

// File: tb/tb_cursor_motion_ctrl.sv
// Bench for cursor_motion_ctrl: directed vector table, mid-operation reset, and random stimulus
// against a tick-counting reference model. Honours CURSOR_DIAG_EN like the design.
module tb_cursor_motion_ctrl;
    localparam int H_MAX = 1279, V_MAX = 1023, X_INIT = 640, Y_INIT = 512;
    localparam int HOLD = 8, RAMP = 4, SMAX = 63;

    localparam logic [4:0] B_N = 5'b00000, B_L = 5'b10000, B_R = 5'b01000;
    localparam logic [4:0] B_U = 5'b00100, B_D = 5'b00010, B_C = 5'b00001;

`ifdef CURSOR_DIAG_EN
    localparam int DX = 665, DY = 510;
    localparam bit DMOV = 1'b1;
`else
    localparam int DX = 666, DY = 511;
    localparam bit DMOV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cursor_motion_ctrl_if ifc();

    cursor_motion_ctrl #(
        .H_MAX(H_MAX), .V_MAX(V_MAX), .X_INIT(X_INIT), .Y_INIT(Y_INIT),
        .HOLD_TICKS(HOLD), .RAMP_TICKS(RAMP), .MAX_SPEED(SMAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cif(ifc)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: position, whether a press is active, ticks since the press began.
    int m_x, m_y, m_spd, m_n, m_cx, m_cy;
    bit m_act, m_pend, m_ovr, m_prevc;
    logic [3:0] m_dir;

    typedef struct {
        bit tick, en, rdy;
        logic [4:0] btn;
        int reps;
        int ex, ey, espd;
        bit emov, ecv, eovr;
        int ecx, ecy;
    } vec_t;
    vec_t tbl[$];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic void add(input bit tick, input bit en, input bit rdy, input logic [4:0] btn,
                                input int reps, input int ex, input int ey, input int espd,
                                input bit emov, input bit ecv, input bit eovr,
                                input int ecx, input int ecy);
        vec_t v;
        v.tick = tick; v.en = en; v.rdy = rdy; v.btn = btn; v.reps = reps;
        v.ex = ex; v.ey = ey; v.espd = espd; v.emov = emov; v.ecv = ecv; v.eovr = eovr;
        v.ecx = ecx; v.ecy = ecy;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = X_INIT; m_y = Y_INIT; m_spd = 0; m_n = 0; m_cx = 0; m_cy = 0;
        m_act = 0; m_pend = 0; m_ovr = 0; m_prevc = 0; m_dir = 4'd0;
    endtask

    task automatic drive(input bit tick, input bit en, input bit rdy, input logic [4:0] btn);
        ifc.step_tick = tick; ifc.cursor_en = en; ifc.click_ready = rdy;
        {ifc.btnL, ifc.btnR, ifc.btnU, ifc.btnD, ifc.btnC} = btn;
    endtask

    // One clock: evaluate the model on the current inputs, clock the DUT, compare everything.
    task automatic cycle();
        logic [3:0] b;
        int nb, st, r;
        bit ok, edge_c;
        int nx, ny, nspd, nn, ncx, ncy;
        bit nact, npend, novr;
        logic [3:0] ndir;
        logic [63:0] act, exp;

        b  = {ifc.btnL, ifc.btnR, ifc.btnU, ifc.btnD};
        nb = int'(ifc.btnL) + int'(ifc.btnR) + int'(ifc.btnU) + int'(ifc.btnD);
`ifdef CURSOR_DIAG_EN
        ok = (nb == 1) || (nb == 2 && (ifc.btnL || ifc.btnR) && (ifc.btnU || ifc.btnD));
`else
        ok = (nb == 1);
`endif
        ok = ok && ifc.cursor_en && !ifc.btnC;

        nx = m_x; ny = m_y; nspd = m_spd; nn = m_n; nact = m_act; ndir = m_dir; st = 0;
        if (!ifc.cursor_en) begin
            nact = 0; nspd = 0;
        end else if (m_act && (!ok || b != m_dir)) begin
            nact = 0; nspd = 0;
        end else if (ifc.step_tick && ok) begin
            if (!m_act) begin
                nact = 1; ndir = b; nn = 0; st = 1;
            end else begin
                nn = m_n + 1;
                if (nn > HOLD) begin
                    r    = nn - HOLD - 1;
                    st   = 1 + imin(r / RAMP, SMAX);
                    nspd = imin((r + 1) / RAMP, SMAX);
                end
            end
        end
        if (st > 0) begin
            if (b[3]) nx = (m_x - st < 0) ? 0 : m_x - st;
            if (b[2]) nx = imin(m_x + st, H_MAX);
            if (b[1]) ny = (m_y - st < 0) ? 0 : m_y - st;
            if (b[0]) ny = imin(m_y + st, V_MAX);
        end

        npend = m_pend; ncx = m_cx; ncy = m_cy; novr = 0;
        edge_c = ifc.btnC && !m_prevc && ifc.cursor_en && (nb == 0);
        if (edge_c) begin
            if (!m_pend || ifc.click_ready) begin
                npend = 1; ncx = m_x; ncy = m_y;
            end else begin
                novr = 1;
            end
        end else if (m_pend && ifc.click_ready) begin
            npend = 0;
        end

        @(posedge clk);
        #1;
        m_x = nx; m_y = ny; m_spd = nspd; m_n = nn; m_act = nact; m_dir = ndir;
        m_pend = npend; m_cx = ncx; m_cy = ncy; m_ovr = novr; m_prevc = ifc.btnC;

        act = 64'({ifc.cursor_x, ifc.cursor_y, ifc.speed, ifc.moving, ifc.click_valid,
                   ifc.click_x, ifc.click_y, ifc.click_overrun});
        exp = 64'({12'(m_x), 12'(m_y), 6'(m_spd), m_act, m_pend, 12'(m_cx), 12'(m_cy), m_ovr});
        check("model{x,y,spd,mov,cv,cx,cy,ovr}", act, exp);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_x"},   64'(ifc.cursor_x), 64'(X_INIT));
        check({tag, "_y"},   64'(ifc.cursor_y), 64'(Y_INIT));
        check({tag, "_spd"}, 64'(ifc.speed), 64'd0);
        check({tag, "_mov"}, 64'(ifc.moving), 64'd0);
        check({tag, "_cv"},  64'(ifc.click_valid), 64'd0);
        check({tag, "_cx"},  64'(ifc.click_x), 64'd0);
        check({tag, "_cy"},  64'(ifc.click_y), 64'd0);
        check({tag, "_ovr"}, 64'(ifc.click_overrun), 64'd0);
    endtask

    initial begin
        logic [4:0] pat;
        int len, sel;

        drive(0, 1, 0, B_N);
        model_reset();
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // tick, en, rdy, btn, reps, x, y, spd, mov, cv, ovr, cx, cy
        add(1, 1, 0, B_R,       1,   641, 512, 0, 1, 0, 0, -1, -1);
        add(0, 1, 0, B_N,       1,   641, 512, 0, 0, 0, 0, -1, -1);
        add(1, 1, 0, B_R,       9,   642, 512, 0, 1, 0, 0, -1, -1);
        add(1, 1, 0, B_R,       4,   646, 512, 1, 1, 0, 0, -1, -1);
        add(1, 1, 0, B_R,       4,   654, 512, 2, 1, 0, 0, -1, -1);
        add(1, 1, 0, B_R,       4,   666, 512, 3, 1, 0, 0, -1, -1);
        add(0, 1, 0, B_U,       1,   666, 512, 0, 0, 0, 0, -1, -1);
        add(1, 1, 0, B_U,       1,   666, 511, 0, 1, 0, 0, -1, -1);
        add(0, 1, 0, B_N,       1,   666, 511, 0, 0, 0, 0, -1, -1);
        add(0, 1, 0, B_C,       1,   666, 511, 0, 0, 1, 0, 666, 511);
        add(0, 1, 0, B_N,       1,   666, 511, 0, 0, 1, 0, 666, 511);
        add(0, 1, 0, B_C,       1,   666, 511, 0, 0, 1, 1, 666, 511);
        add(0, 1, 1, B_C,       3,   666, 511, 0, 0, 0, 0, 666, 511);
        add(1, 1, 0, B_L | B_U, 1,   DX,  DY,  0, DMOV, 0, 0, -1, -1);
        add(0, 1, 0, B_N,       1,   DX,  DY,  0, 0, 0, 0, -1, -1);
        add(1, 1, 0, B_L | B_R, 1,   DX,  DY,  0, 0, 0, 0, -1, -1);
        add(1, 1, 0, B_R,       3,   DX + 1, DY, 0, 1, 0, 0, -1, -1);
        add(1, 0, 0, B_R,       2,   DX + 1, DY, 0, 0, 0, 0, -1, -1);
        add(0, 1, 0, B_N,       1,   DX + 1, DY, 0, 0, 0, 0, -1, -1);
        add(1, 1, 0, B_L,       200, 0,   DY,  47, 1, 0, 0, -1, -1);
        add(1, 1, 0, B_L,       4,   0,   DY,  48, 1, 0, 0, -1, -1);
        add(0, 1, 0, B_N,       1,   0,   DY,  0, 0, 0, 0, -1, -1);
        add(1, 1, 0, B_D,       200, 0,   1023, 47, 1, 0, 0, -1, -1);
        add(0, 1, 0, B_N,       1,   0,   1023, 0, 0, 0, 0, -1, -1);
        add(1, 1, 0, B_C | B_R, 2,   0,   1023, 0, 0, 0, 0, -1, -1);
        add(0, 1, 0, B_N,       1,   0,   1023, 0, 0, 0, 0, -1, -1);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].tick, tbl[i].en, tbl[i].rdy, tbl[i].btn);
            repeat (tbl[i].reps) cycle();
            check($sformatf("vec%0d_x", i),   64'(ifc.cursor_x), 64'(tbl[i].ex));
            check($sformatf("vec%0d_y", i),   64'(ifc.cursor_y), 64'(tbl[i].ey));
            check($sformatf("vec%0d_spd", i), 64'(ifc.speed), 64'(tbl[i].espd));
            check($sformatf("vec%0d_mov", i), 64'(ifc.moving), 64'(tbl[i].emov));
            check($sformatf("vec%0d_cv", i),  64'(ifc.click_valid), 64'(tbl[i].ecv));
            check($sformatf("vec%0d_ovr", i), 64'(ifc.click_overrun), 64'(tbl[i].eovr));
            if (tbl[i].ecx >= 0) begin
                check($sformatf("vec%0d_cx", i), 64'(ifc.click_x), 64'(tbl[i].ecx));
                check($sformatf("vec%0d_cy", i), 64'(ifc.click_y), 64'(tbl[i].ecy));
            end
        end

        // Pending click plus active repeat, then asynchronous reset between clock edges.
        drive(0, 1, 0, B_C);
        cycle();
        drive(1, 1, 0, B_R);
        repeat (12) cycle();
        check("pre_reset_cv",  64'(ifc.click_valid), 64'd1);
        check("pre_reset_mov", 64'(ifc.moving), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        drive(0, 1, 0, B_N);
        @(negedge clk);
        rst_n = 1'b1;

        for (int ep = 0; ep < 45; ep++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    pat = B_R;
                2:       pat = B_L;
                3:       pat = B_U;
                4:       pat = B_D;
                5:       pat = (($urandom_range(0, 1) == 0) ? B_L : B_R) | (($urandom_range(0, 1) == 0) ? B_U : B_D);
                6, 7:    pat = B_C;
                8:       pat = B_N;
                default: pat = 5'($urandom_range(0, 31));
            endcase
            len = ((ep % 6) == 0) ? $urandom_range(150, 320) : $urandom_range(1, 60);
            for (int c = 0; c < len; c++) begin
                drive(($urandom_range(0, 2) != 0), ($urandom_range(0, 40) != 0),
                      ($urandom_range(0, 3) == 0), pat);
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
